// File: rtl/bsg_mc_link_credit_gate.sv
// bsg_mc_link_credit_gate
//
// Forward-path credit gate for one manycore proc link, BP clock domain.
// Outgoing forward packets are held in a 2-entry in-order buffer and are
// released toward the fwd CDC link only while outstanding-request credits
// remain. Returning reverse responses restore credits. A fence stops issue
// until every outstanding request has been answered.
//
// Optional feature macro: BSG_MC_CREDIT_GATE_ERROR_EN
//   defined   : error_o is a sticky credit-overflow flag and a simulation
//               assertion fires on overflow.
//   undefined : error_o is tied low. The counter still saturates at max.

module bsg_mc_link_credit_gate
  #(// Payload width. No meaningful default exists, so every instance must
    // set this explicitly. The default only keeps stand-alone lint happy.
    parameter int packet_width_p = 32
   ,parameter int max_out_credits_p = 32
   ,localparam int credit_width_lp = $clog2(max_out_credits_p+1)
   )
  (input  logic                       clk_i
  ,input  logic                       reset_i

  ,input  logic [packet_width_p-1:0]  fwd_data_i
  ,input  logic                       fwd_v_i
  ,output logic                       fwd_ready_o

  ,output logic [packet_width_p-1:0]  fwd_data_o
  ,output logic                       fwd_v_o
  ,input  logic                       fwd_ready_i

  ,input  logic                       resp_v_i
  ,input  logic                       fence_i
  ,output logic                       fence_done_o

  ,output logic [credit_width_lp-1:0] credits_o
  ,output logic                       idle_o
  ,output logic                       error_o
  );

  localparam logic [credit_width_lp-1:0] max_credits_lp =
    credit_width_lp'(max_out_credits_p);

  typedef enum logic [0:0] {
    S_NORMAL = 1'b0,
    S_DRAIN  = 1'b1
  } state_e;

  // Buffer storage and occupancy
  logic [packet_width_p-1:0] mem_q [2];
  logic                      wptr_q, rptr_q;
  logic [1:0]                count_q, count_d;
  logic                      full, empty;
  logic                      enq, deq;

  // Credit / fence control
  logic [credit_width_lp-1:0] credits_q, credits_d;
  state_e                     state_q, state_d;
  logic                       fence_done_q, fence_done_d;
  logic                       idle_q, idle_d;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

  // Ready only reflects buffer space; credits and fences never backpressure
  // the tile, so packets keep accumulating during a drain.
  assign fwd_ready_o = ~reset_i & ~full;

  // Valid is decided from the current state only, so a dequeue in the cycle
  // a fence arrives still completes.
  assign fwd_v_o    = ~reset_i & ~empty & (credits_q != '0) & (state_q == S_NORMAL);
  assign fwd_data_o = mem_q[rptr_q];

  assign enq = fwd_v_i & fwd_ready_o;
  assign deq = fwd_v_o & fwd_ready_i;

  // Payload storage; contents are only meaningful under the occupancy count.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr_q] <= fwd_data_i;
    end
  end

  // Next occupancy from simultaneous enqueue/dequeue.
  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Buffer pointers and occupancy; reset discards anything buffered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (enq) wptr_q <= ~wptr_q;
      if (deq) rptr_q <= ~rptr_q;
      count_q <= count_d;
    end
  end

  // Credit counter: a dequeue spends one, a response returns one, both
  // together cancel. A return at max saturates instead of wrapping.
  always_comb begin
    credits_d = credits_q;
    if (resp_v_i & ~deq) begin
      if (credits_q != max_credits_lp) begin
        credits_d = credits_q + 1'b1;
      end
    end else if (deq & ~resp_v_i) begin
      credits_d = credits_q - 1'b1;
    end
  end

  // Fence FSM: leave DRAIN as soon as the upcoming credit value shows every
  // request answered; the done pulse lands in the first NORMAL cycle.
  always_comb begin
    state_d      = state_q;
    fence_done_d = 1'b0;
    case (state_q)
      S_NORMAL: begin
        if (fence_i) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (credits_d == max_credits_lp) begin
          state_d      = S_NORMAL;
          fence_done_d = 1'b1;
        end
      end
      default: state_d = S_NORMAL;
    endcase
  end

  assign idle_d = (credits_d == max_credits_lp) & (count_d == 2'd0);

  // Control registers: FSM state, done pulse, credit count and idle flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_NORMAL;
      fence_done_q <= 1'b0;
      credits_q    <= max_credits_lp;
      idle_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      fence_done_q <= fence_done_d;
      credits_q    <= credits_d;
      idle_q       <= idle_d;
    end
  end

  assign fence_done_o = fence_done_q;
  assign credits_o    = credits_q;
  assign idle_o       = idle_q;

`ifdef BSG_MC_CREDIT_GATE_ERROR_EN
  logic overflow;
  logic error_q;

  // A response arriving with nothing outstanding means the far side returned
  // more credits than were spent.
  assign overflow = resp_v_i & ~deq & (credits_q == max_credits_lp);

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      error_q <= 1'b0;
    end else if (overflow) begin
      error_q <= 1'b1;
    end
  end

  assign error_o = error_q;

  a_no_credit_overflow: assert property (
    @(posedge clk_i) disable iff (reset_i) !overflow
  ) else $error("bsg_mc_link_credit_gate: credit overflow");
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_mc_link_credit_gate.sv
// Self-checking bench for bsg_mc_link_credit_gate (packet width 16, 32 credits).
// A negedge monitor keeps an in-order scoreboard of accepted packets and
// compares every departing packet against it.

module tb_bsg_mc_link_credit_gate;

  localparam int PW = 16;
  localparam int MAXC = 32;
  localparam int CW = $clog2(MAXC+1);

  logic          clk;
  logic          reset_i;
  logic [PW-1:0] fwd_data_i;
  logic          fwd_v_i;
  logic          fwd_ready_o;
  logic [PW-1:0] fwd_data_o;
  logic          fwd_v_o;
  logic          fwd_ready_i;
  logic          resp_v_i;
  logic          fence_i;
  logic          fence_done_o;
  logic [CW-1:0] credits_o;
  logic          idle_o;
  logic          error_o;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  logic [PW-1:0] sb_q[$];

  bsg_mc_link_credit_gate #(
    .packet_width_p(PW),
    .max_out_credits_p(MAXC)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .fwd_data_i(fwd_data_i),
    .fwd_v_i(fwd_v_i),
    .fwd_ready_o(fwd_ready_o),
    .fwd_data_o(fwd_data_o),
    .fwd_v_o(fwd_v_o),
    .fwd_ready_i(fwd_ready_i),
    .resp_v_i(resp_v_i),
    .fence_i(fence_i),
    .fence_done_o(fence_done_o),
    .credits_o(credits_o),
    .idle_o(idle_o),
    .error_o(error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: pop/compare on dequeue, push on enqueue.
  always @(negedge clk) begin
    if (reset_i) begin
      sb_q.delete();
    end else begin
      if (fwd_v_o && fwd_ready_i) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got %h required none", fwd_data_o);
        end else begin
          logic [PW-1:0] exp_d;
          exp_d = sb_q.pop_front();
          if (fwd_data_o !== exp_d) begin
            errors++;
            $display("FAIL sb_data got %h required %h", fwd_data_o, exp_d);
          end
        end
        out_cnt++;
      end
      if (fwd_v_i && fwd_ready_o) sb_q.push_back(fwd_data_i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if (fwd_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b required 0", fwd_ready_o); end
    checks++; if (fwd_v_o !== 1'b0) begin errors++; $display("FAIL rst_v got %b required 0", fwd_v_o); end
    checks++; if (credits_o !== CW'(MAXC)) begin errors++; $display("FAIL rst_credits got %0d required %0d", credits_o, MAXC); end
    checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL rst_idle got %b required 1", idle_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL rst_error got %b required 0", error_o); end
    checks++; if (fence_done_o !== 1'b0) begin errors++; $display("FAIL rst_fdone got %b required 0", fence_done_o); end
    tick();
    reset_i = 1'b0;
    @(negedge clk);
    checks++; if (fwd_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b required 1", fwd_ready_o); end
    tick();
  endtask

  task automatic test_stream();
    int sent = 0;
    int o0;
    o0 = out_cnt;
    fwd_ready_i = 1'b1;
    for (int c = 0; c < 60; c++) begin
      fwd_v_i = (sent < 40);
      fwd_data_i = PW'(16'h1000 + sent);
      @(negedge clk);
      if (fwd_v_i && fwd_ready_o) sent++;
      tick();
    end
    fwd_v_i = 1'b0;
    checks++; if (out_cnt - o0 != 32) begin errors++; $display("FAIL stream_out got %0d required 32", out_cnt - o0); end
    checks++; if (sent != 34) begin errors++; $display("FAIL stream_accepted got %0d required 34", sent); end
    @(negedge clk);
    checks++; if (credits_o !== CW'(0)) begin errors++; $display("FAIL stream_credits got %0d required 0", credits_o); end
    checks++; if (fwd_v_o !== 1'b0) begin errors++; $display("FAIL stream_v got %b required 0", fwd_v_o); end
    checks++; if (fwd_ready_o !== 1'b0) begin errors++; $display("FAIL stream_ready got %b required 0", fwd_ready_o); end
    checks++; if (idle_o !== 1'b0) begin errors++; $display("FAIL stream_idle got %b required 0", idle_o); end
    tick();
  endtask

  task automatic test_resp_release();
    int o0;
    o0 = out_cnt;
    resp_v_i = 1'b1;
    tick();
    resp_v_i = 1'b0;
    @(negedge clk);
    checks++; if (credits_o !== CW'(1)) begin errors++; $display("FAIL rel_credits got %0d required 1", credits_o); end
    checks++; if (fwd_v_o !== 1'b1) begin errors++; $display("FAIL rel_v got %b required 1", fwd_v_o); end
    tick();
    @(negedge clk);
    checks++; if (credits_o !== CW'(0)) begin errors++; $display("FAIL rel_credits0 got %0d required 0", credits_o); end
    checks++; if (fwd_v_o !== 1'b0) begin errors++; $display("FAIL rel_v0 got %b required 0", fwd_v_o); end
    tick();
    checks++; if (out_cnt - o0 != 1) begin errors++; $display("FAIL rel_out got %0d required 1", out_cnt - o0); end
  endtask

  task automatic test_simul();
    fwd_ready_i = 1'b0;
    resp_v_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    resp_v_i = 1'b0;
    @(negedge clk);
    checks++; if (credits_o !== CW'(5)) begin errors++; $display("FAIL sim_pre_credits got %0d required 5", credits_o); end
    checks++; if (fwd_v_o !== 1'b1) begin errors++; $display("FAIL sim_pre_v got %b required 1", fwd_v_o); end
    checks++; if (fwd_data_o !== 16'h1021) begin errors++; $display("FAIL sim_head got %h required 1021", fwd_data_o); end
    tick();
    fwd_ready_i = 1'b1;
    resp_v_i = 1'b1;
    tick();
    resp_v_i = 1'b0;
    @(negedge clk);
    checks++; if (credits_o !== CW'(5)) begin errors++; $display("FAIL sim_credits got %0d required 5", credits_o); end
    checks++; if (fwd_v_o !== 1'b0) begin errors++; $display("FAIL sim_v got %b required 0", fwd_v_o); end
    tick();
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sim_sb_left got %0d required 0", sb_q.size()); end
  endtask

  task automatic test_fence();
    int o0;
    int done_cnt = 0;
    resp_v_i = 1'b1;
    for (int i = 0; i < 24; i++) tick();
    resp_v_i = 1'b0;
    @(negedge clk);
    checks++; if (credits_o !== CW'(29)) begin errors++; $display("FAIL fen_pre_credits got %0d required 29", credits_o); end
    tick();
    fence_i = 1'b1; fwd_v_i = 1'b1; fwd_data_i = 16'hA000;
    tick();
    fence_i = 1'b0; fwd_data_i = 16'hA001;
    @(negedge clk);
    checks++; if (fwd_v_o !== 1'b0) begin errors++; $display("FAIL fen_v_drain got %b required 0", fwd_v_o); end
    tick();
    fwd_v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (fwd_v_o !== 1'b0 || fence_done_o !== 1'b0) begin errors++; $display("FAIL fen_wait%0d got v=%b done=%b required v=0 done=0", i, fwd_v_o, fence_done_o); end
      tick();
    end
    resp_v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (fwd_v_o !== 1'b0 || fence_done_o !== 1'b0) begin errors++; $display("FAIL fen_resp%0d got v=%b done=%b required v=0 done=0", i, fwd_v_o, fence_done_o); end
      tick();
    end
    resp_v_i = 1'b0;
    o0 = out_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (fence_done_o === 1'b1) done_cnt++;
      if (i == 0) begin
        checks++; if (fence_done_o !== 1'b1 || fwd_v_o !== 1'b1) begin errors++; $display("FAIL fen_resume got done=%b v=%b required done=1 v=1", fence_done_o, fwd_v_o); end
      end
      tick();
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL fen_done_count got %0d required 1", done_cnt); end
    checks++; if (out_cnt - o0 != 2) begin errors++; $display("FAIL fen_out got %0d required 2", out_cnt - o0); end
    resp_v_i = 1'b1;
    tick(); tick();
    resp_v_i = 1'b0;
    @(negedge clk);
    checks++; if (credits_o !== CW'(MAXC) || idle_o !== 1'b1) begin errors++; $display("FAIL fen_post got credits=%0d idle=%b required credits=32 idle=1", credits_o, idle_o); end
    tick();
  endtask

  task automatic test_fence_idle();
    fence_i = 1'b1; fwd_v_i = 1'b1; fwd_data_i = 16'hB000;
    @(negedge clk);
    checks++; if (idle_o !== 1'b1 || fence_done_o !== 1'b0) begin errors++; $display("FAIL fi_t0 got idle=%b done=%b required idle=1 done=0", idle_o, fence_done_o); end
    tick();
    fence_i = 1'b0; fwd_v_i = 1'b0;
    @(negedge clk);
    checks++; if (fwd_v_o !== 1'b0 || fence_done_o !== 1'b0) begin errors++; $display("FAIL fi_t1 got v=%b done=%b required v=0 done=0", fwd_v_o, fence_done_o); end
    tick();
    @(negedge clk);
    checks++; if (fwd_v_o !== 1'b1 || fence_done_o !== 1'b1) begin errors++; $display("FAIL fi_t2 got v=%b done=%b required v=1 done=1", fwd_v_o, fence_done_o); end
    tick();
    @(negedge clk);
    checks++; if (fence_done_o !== 1'b0 || credits_o !== CW'(31)) begin errors++; $display("FAIL fi_t3 got done=%b credits=%0d required done=0 credits=31", fence_done_o, credits_o); end
    resp_v_i = 1'b1;
    tick();
    resp_v_i = 1'b0;
  endtask

  task automatic test_overflow();
    logic exp_err;
`ifdef BSG_MC_CREDIT_GATE_ERROR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    @(negedge clk);
    checks++; if (credits_o !== CW'(MAXC)) begin errors++; $display("FAIL ovf_pre got %0d required 32", credits_o); end
    resp_v_i = 1'b1;
    tick();
    resp_v_i = 1'b0;
    @(negedge clk);
    checks++; if (credits_o !== CW'(MAXC)) begin errors++; $display("FAIL ovf_credits got %0d required 32", credits_o); end
    checks++; if (error_o !== exp_err) begin errors++; $display("FAIL ovf_error got %b required %b", error_o, exp_err); end
    checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL ovf_idle got %b required 1", idle_o); end
    tick();
  endtask

  task automatic test_mid_reset();
    fwd_ready_i = 1'b1; fwd_v_i = 1'b1; fwd_data_i = 16'hC000;
    tick();
    fwd_v_i = 1'b0;
    tick();
    fwd_ready_i = 1'b0; fwd_v_i = 1'b1; fwd_data_i = 16'hC001;
    tick();
    fwd_v_i = 1'b0; fence_i = 1'b1;
    tick();
    fence_i = 1'b0;
    @(negedge clk);
    checks++; if (credits_o !== CW'(31) || fwd_v_o !== 1'b0) begin errors++; $display("FAIL mr_pre got credits=%0d v=%b required credits=31 v=0", credits_o, fwd_v_o); end
    tick();
    reset_i = 1'b1; fwd_ready_i = 1'b1;
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (fence_done_o !== 1'b0 || fwd_v_o !== 1'b0 || credits_o !== CW'(MAXC) || idle_o !== 1'b1 || error_o !== 1'b0) begin
        errors++;
        $display("FAIL mr_post%0d got done=%b v=%b credits=%0d idle=%b err=%b required 0 0 32 1 0", i, fence_done_o, fwd_v_o, credits_o, idle_o, error_o);
      end
      tick();
    end
  endtask

  initial begin
    reset_i = 1'b1;
    fwd_data_i = '0;
    fwd_v_i = 1'b0;
    fwd_ready_i = 1'b0;
    resp_v_i = 1'b0;
    fence_i = 1'b0;
    test_reset();
    test_stream();
    test_resp_release();
    test_simul();
    test_fence();
    test_fence_idle();
    test_overflow();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
